// File: rtl/fifo_ptr_ctrl_if.sv
// Handshake/status bundle for one side of a dual-clock FIFO pointer controller.
// The master is the user of the FIFO side: it raises inc and delivers the
// opposite domain's synchronised Gray pointer. The slave is fifo_ptr_ctrl.
interface fifo_ptr_ctrl_if #(
    parameter int ADDR_W = 3
);
    localparam int PTR_W = ADDR_W + 1;

    logic              inc;
    logic [PTR_W-1:0]  sync_ptr_gray;
    logic              accept;
    logic [ADDR_W-1:0] addr;
    logic [PTR_W-1:0]  ptr_bin;
    logic [PTR_W-1:0]  ptr_gray;
    logic              flag;
    logic              almost;
    logic [PTR_W-1:0]  level;
    logic              err;

    modport master (
        output inc, sync_ptr_gray,
        input  accept, addr, ptr_bin, ptr_gray, flag, almost, level, err
    );

    modport slave (
        input  inc, sync_ptr_gray,
        output accept, addr, ptr_bin, ptr_gray, flag, almost, level, err
    );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Gray-coded FIFO pointer and flag generator for one clock domain of a
// dual-clock FIFO. IS_WR=0 gives the read side (flag = empty), IS_WR=1 the
// write side (flag = full). Only ptr_gray is meant to leave this domain.
module fifo_ptr_ctrl #(
    parameter int ADDR_W     = 3,
    parameter int IS_WR      = 0,
    parameter int RESET_BIN  = 0,
    parameter int ALMOST_THR = 1
) (
    input  logic            clk,
    input  logic            reset,
    fifo_ptr_ctrl_if.slave  bus
);
    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [PTR_W-1:0] RST_BIN  = PTR_W'(RESET_BIN);
    localparam logic [PTR_W-1:0] RST_GRAY = RST_BIN ^ (RST_BIN >> 1);
    // Full means the Gray pointers differ exactly in their top two bits.
    localparam logic [PTR_W-1:0] FULL_MASK = PTR_W'(3) << (PTR_W - 2);
    localparam logic [PTR_W-1:0] AE_LVL    = PTR_W'(ALMOST_THR);
    localparam logic [PTR_W-1:0] AF_LVL    = PTR_W'(DEPTH - ALMOST_THR);
    localparam logic             RST_FLAG  = (IS_WR == 0);
    localparam logic             RST_ALM   = (IS_WR == 0) ? 1'b1 : (ALMOST_THR >= DEPTH);

    logic [PTR_W-1:0] bin_q;
    logic [PTR_W-1:0] gray_q;
    logic [PTR_W-1:0] level_q;
    logic             flag_q;
    logic             almost_q;
    logic             err_q;

    logic             accept;
    logic [PTR_W-1:0] next_bin;
    logic [PTR_W-1:0] next_gray;
    logic [PTR_W-1:0] other_bin;
    logic [PTR_W-1:0] next_level;
    logic             next_flag;
    logic             next_almost;

    // Decision uses only the registered flag, keeping sync_ptr_gray off the accept path.
    assign accept    = bus.inc & ~flag_q;
    assign next_bin  = bin_q + {{(PTR_W-1){1'b0}}, accept};
    assign next_gray = next_bin ^ (next_bin >> 1);

    // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        other_bin = '0;
        for (int i = 0; i < PTR_W; i++) begin
            other_bin[i] = ^(bus.sync_ptr_gray >> i);
        end
    end

    // Lookahead occupancy and flags, already including this cycle's accept.
    always_comb begin
        next_level  = '0;
        next_flag   = 1'b0;
        next_almost = 1'b0;
        if (IS_WR != 0) begin
            next_level  = next_bin - other_bin;
            next_flag   = (next_gray == (bus.sync_ptr_gray ^ FULL_MASK));
            next_almost = (next_level >= AF_LVL);
        end else begin
            next_level  = other_bin - next_bin;
            next_flag   = (next_gray == bus.sync_ptr_gray);
            next_almost = (next_level <= AE_LVL);
        end
    end

    // Pointer and flag registers; reset wins over inc.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q    <= RST_BIN;
            gray_q   <= RST_GRAY;
            level_q  <= '0;
            flag_q   <= RST_FLAG;
            almost_q <= RST_ALM;
        end else begin
            bin_q    <= next_bin;
            gray_q   <= next_gray;
            level_q  <= next_level;
            flag_q   <= next_flag;
            almost_q <= next_almost;
        end
    end

    // Sticky error: a request arriving while the flag blocks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (bus.inc & flag_q) begin
            err_q <= 1'b1;
        end
    end

    assign bus.accept   = accept;
    assign bus.addr     = bin_q[ADDR_W-1:0];
    assign bus.ptr_bin  = bin_q;
    assign bus.ptr_gray = gray_q;
    assign bus.flag     = flag_q;
    assign bus.almost   = almost_q;
    assign bus.level    = level_q;
    assign bus.err      = err_q;
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Bench for fifo_ptr_ctrl: one read-side instance (RESET_BIN=15, ALMOST_THR=1)
// and one write-side instance (RESET_BIN=0, ALMOST_THR=2), each driven with its
// own opposite-pointer stream and compared to an occupancy-based model.
module tb_fifo_ptr_ctrl;
    localparam int AW    = 3;
    localparam int PW    = AW + 1;
    localparam int DEPTH = 1 << AW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR_W(AW)) bus_rd();
    fifo_ptr_ctrl_if #(.ADDR_W(AW)) bus_wr();

    fifo_ptr_ctrl #(.ADDR_W(AW), .IS_WR(0), .RESET_BIN(15), .ALMOST_THR(1)) u_rd (
        .clk(clk), .reset(reset), .bus(bus_rd.slave)
    );
    fifo_ptr_ctrl #(.ADDR_W(AW), .IS_WR(1), .RESET_BIN(0), .ALMOST_THR(2)) u_wr (
        .clk(clk), .reset(reset), .bus(bus_wr.slave)
    );

    // side 0 = read, side 1 = write
    logic [PW-1:0] o_bin [2];
    logic [PW-1:0] o_gray[2];
    logic [AW-1:0] o_addr[2];
    logic [PW-1:0] o_lvl [2];
    logic          o_flag[2];
    logic          o_alm [2];
    logic          o_err [2];
    logic          o_acc [2];

    assign o_bin[0]  = bus_rd.ptr_bin;   assign o_bin[1]  = bus_wr.ptr_bin;
    assign o_gray[0] = bus_rd.ptr_gray;  assign o_gray[1] = bus_wr.ptr_gray;
    assign o_addr[0] = bus_rd.addr;      assign o_addr[1] = bus_wr.addr;
    assign o_lvl[0]  = bus_rd.level;     assign o_lvl[1]  = bus_wr.level;
    assign o_flag[0] = bus_rd.flag;      assign o_flag[1] = bus_wr.flag;
    assign o_alm[0]  = bus_rd.almost;    assign o_alm[1]  = bus_wr.almost;
    assign o_err[0]  = bus_rd.err;       assign o_err[1]  = bus_wr.err;
    assign o_acc[0]  = bus_rd.accept;    assign o_acc[1]  = bus_wr.accept;

    int    n_checks = 0;
    int    n_errors = 0;
    string nm [2] = '{"rd", "wr"};
    int    rb [2] = '{15, 0};
    int    thr[2] = '{1, 2};

    // reference model: pointers as plain counters, occupancy by subtraction
    int          m_mine [2];
    int          m_other[2];
    int          m_lvl  [2];
    bit          m_flag [2];
    bit          m_alm  [2];
    bit          m_err  [2];
    bit          model_valid = 1'b0;
    int          rd_accepts = 0;
    bit          rd_wrapped = 1'b0;
    logic [PW-1:0] prev_gray[2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] gray(input int b);
        logic [PW-1:0] v;
        v = PW'(b);
        return v ^ (v >> 1);
    endfunction

    task automatic step(input bit rst, input bit inc_r, input bit inc_w,
                        input int oth_r, input int oth_w);
        bit inc_a[2];
        int oth_a[2];
        bit acc;
        int occ;
        inc_a = '{inc_r, inc_w};
        oth_a = '{oth_r, oth_w};
        reset             = rst;
        bus_rd.inc        = inc_r;
        bus_wr.inc        = inc_w;
        bus_rd.sync_ptr_gray = gray(oth_r);
        bus_wr.sync_ptr_gray = gray(oth_w);
        for (int s = 0; s < 2; s++) prev_gray[s] = o_gray[s];
        @(negedge clk);
        if (model_valid && !rst) begin
            for (int s = 0; s < 2; s++)
                check($sformatf("%s_accept", nm[s]), o_acc[s], inc_a[s] && !m_flag[s]);
        end
        @(posedge clk);
        for (int s = 0; s < 2; s++) begin
            if (rst) begin
                m_mine[s]  = rb[s];
                m_other[s] = rb[s];
                m_lvl[s]   = 0;
                m_flag[s]  = (s == 0);
                m_alm[s]   = (s == 0);
                m_err[s]   = 1'b0;
            end else begin
                acc = inc_a[s] && !m_flag[s];
                if (inc_a[s] && m_flag[s]) m_err[s] = 1'b1;
                if (s == 0 && acc) begin
                    rd_accepts++;
                    if (m_mine[0] == 15) rd_wrapped = 1'b1;
                end
                m_mine[s]  = (m_mine[s] + int'(acc)) % 16;
                m_other[s] = oth_a[s] % 16;
                occ = (s == 1) ? ((m_mine[s] - m_other[s]) & 15)
                               : ((m_other[s] - m_mine[s]) & 15);
                m_lvl[s]  = occ;
                m_flag[s] = (s == 1) ? (occ == DEPTH) : (occ == 0);
                m_alm[s]  = (s == 1) ? (occ >= DEPTH - thr[s]) : (occ <= thr[s]);
            end
        end
        model_valid = 1'b1;
        #1;
        for (int s = 0; s < 2; s++) begin
            check($sformatf("%s_ptr_bin", nm[s]),  o_bin[s],  m_mine[s]);
            check($sformatf("%s_ptr_gray", nm[s]), o_gray[s], gray(m_mine[s]));
            check($sformatf("%s_addr", nm[s]),     o_addr[s], m_mine[s] % DEPTH);
            check($sformatf("%s_level", nm[s]),    o_lvl[s],  m_lvl[s]);
            check($sformatf("%s_flag", nm[s]),     o_flag[s], m_flag[s]);
            check($sformatf("%s_almost", nm[s]),   o_alm[s],  m_alm[s]);
            check($sformatf("%s_err", nm[s]),      o_err[s],  m_err[s]);
            if (!rst)
                check($sformatf("%s_gray_1bit", nm[s]),
                      $countones(prev_gray[s] ^ o_gray[s]) <= 1, 1);
        end
    endtask

    initial begin
        int orp;
        int owp;
        bit r;

        // reset held two cycles with inc high
        step(1, 1, 1, 15, 0);
        step(1, 1, 1, 15, 0);
        check("rd_reset_gray", o_gray[0], 4'b1000);
        check("wr_reset_gray", o_gray[1], 4'b0000);
        check("wr_reset_flag", o_flag[1], 0);
        check("rd_reset_flag", o_flag[0], 1);

        // write side fills to full; read side sees 3 entries and drains them
        for (int i = 0; i < 9; i++) begin
            step(0, (i >= 1 && i <= 4), 1, 2, 0);
            check($sformatf("wr_fill_level_%0d", i), o_lvl[1], (i < 8) ? i + 1 : 8);
            if (i == 0) check("rd_drain_level3", o_lvl[0], 3);
            if (i == 3) check("rd_drain_empty", o_flag[0], 1);
            if (i == 4) check("rd_drain_err", o_err[0], 1);
            if (i == 7) begin
                check("wr_full_flag", o_flag[1], 1);
                check("wr_full_gray", o_gray[1], 4'b1100);
            end
        end
        check("wr_overflow_err", o_err[1], 1);
        check("wr_overflow_hold", o_bin[1], 8);

        // full with inc and a read-pointer step in the same cycle
        step(0, 0, 1, 2, 1);
        check("wr_simul_level", o_lvl[1], 7);
        check("wr_simul_flag", o_flag[1], 0);
        step(0, 0, 1, 2, 1);
        check("wr_simul_next_acc", o_lvl[1], 8);

        // almost-full at level 6, then reset mid-operation with inc high
        step(1, 0, 0, 15, 0);
        for (int i = 0; i < 11; i++) begin
            step(0, 0, 1, 15, 0);
            if (i == 4) check("wr_almost_l5", o_alm[1], 0);
            if (i == 5) check("wr_almost_l6", o_alm[1], 1);
        end
        step(1, 0, 1, 15, 0);
        check("wr_midreset_bin", o_bin[1], 0);
        check("wr_midreset_level", o_lvl[1], 0);
        check("wr_midreset_almost", o_alm[1], 0);
        check("wr_midreset_err", o_err[1], 0);

        // randomized traffic with opposite pointers walking within legal bounds
        rd_accepts = 0;
        rd_wrapped = 1'b0;
        orp = m_other[0];
        owp = m_other[1];
        for (int c = 0; c < 800; c++) begin
            r = ($urandom_range(0, 199) == 0);
            if (r) begin
                orp = 15;
                owp = 0;
            end else begin
                if (((orp - m_mine[0]) & 15) < DEPTH && $urandom_range(0, 3) != 0)
                    orp = (orp + 1) % 16;
                if (((m_mine[1] - owp) & 15) > 0 && $urandom_range(0, 1) != 0)
                    owp = (owp + 1) % 16;
            end
            step(r, $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, orp, owp);
        end
        check("rd_many_accepts", rd_accepts >= 32, 1);
        check("rd_wrap_seen", rd_wrapped, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
